// File: rtl/hp_smpl_queue.sv
// hp_smpl_queue: dual-channel circular sample queue replaying the newest TAPS samples to the high-pass FIR
// Define HP_QUEUE_OVFL_EN to add the sticky ovfl output.
module hp_smpl_queue #(
  parameter int DEPTH = 1024,
  parameter int TAPS  = 1021
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wrt_smpl,
  input  logic signed [15:0] lft_smpl,
  input  logic signed [15:0] rght_smpl,
  output logic signed [15:0] lft_out,
  output logic signed [15:0] rght_out,
`ifdef HP_QUEUE_OVFL_EN
  output logic               ovfl,
`endif
  output logic               sequencing
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TAPS + 1);
  localparam int WW = $clog2(DEPTH - TAPS + 2);
  typedef enum logic [1:0] {FILL, IDLE, START, SEQ} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] new_ptr_q, new_ptr_d, rd_ptr_q, rd_ptr_d, rd_addr;
  logic [CW-1:0] cnt_q, cnt_d, k_q, k_d;
  logic [WW-1:0] wr_cnt_q, wr_cnt_d;
  logic pend_q, pend_d, sequencing_q, sequencing_d, rd_en, to_start, busy;
  logic signed [15:0] lft_out_q, lft_out_d, rght_out_q, rght_out_d;
  logic signed [15:0] mem_l [DEPTH];
  logic signed [15:0] mem_r [DEPTH];
  always_comb begin
    state_d = state_q;
    to_start = 1'b0;
    rd_en = 1'b0;
    rd_addr = rd_ptr_q;
    rd_ptr_d = rd_ptr_q;
    k_d = k_q;
    case (state_q)
      FILL: to_start = wrt_smpl && cnt_q == CW'(TAPS - 1);
      IDLE: to_start = wrt_smpl;
      START: begin
        rd_en = 1'b1;
        rd_addr = new_ptr_q - AW'(TAPS);
        rd_ptr_d = rd_addr + AW'(1);
        k_d = CW'(1);
        state_d = SEQ;
      end
      default: begin
        // the final SEQ cycle issues no read, giving the FIR a one-cycle gap
        rd_en = k_q != CW'(TAPS);
        rd_ptr_d = rd_ptr_q + AW'(rd_en);
        k_d = k_q + CW'(rd_en);
        to_start = !rd_en && (pend_q || wrt_smpl);
        state_d = rd_en ? SEQ : IDLE;
      end
    endcase
    if (to_start) state_d = START;
  end
  assign busy = state_q == START || state_q == SEQ;
  assign pend_d = to_start ? 1'b0 : (wrt_smpl && busy) ? 1'b1 : pend_q;
  assign cnt_d = (wrt_smpl && cnt_q != CW'(TAPS)) ? cnt_q + CW'(1) : cnt_q;
  assign new_ptr_d = new_ptr_q + AW'(wrt_smpl);
  assign wr_cnt_d = to_start ? '0 : (wrt_smpl && busy && wr_cnt_q <= WW'(DEPTH - TAPS)) ? wr_cnt_q + WW'(1) : wr_cnt_q;
  assign sequencing_d = rd_en;
  assign lft_out_d = rd_en ? mem_l[rd_addr] : lft_out_q;
  assign rght_out_d = rd_en ? mem_r[rd_addr] : rght_out_q;
  always_ff @(posedge clk)
    if (wrt_smpl) begin
      mem_l[new_ptr_q] <= lft_smpl;
      mem_r[new_ptr_q] <= rght_smpl;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= FILL;
      new_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
      k_q <= '0;
      wr_cnt_q <= '0;
      pend_q <= 1'b0;
      sequencing_q <= 1'b0;
      lft_out_q <= '0;
      rght_out_q <= '0;
    end else begin
      state_q <= state_d;
      new_ptr_q <= new_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
      k_q <= k_d;
      wr_cnt_q <= wr_cnt_d;
      pend_q <= pend_d;
      sequencing_q <= sequencing_d;
      lft_out_q <= lft_out_d;
      rght_out_q <= rght_out_d;
    end
  assign lft_out = lft_out_q;
  assign rght_out = rght_out_q;
  assign sequencing = sequencing_q;
`ifdef HP_QUEUE_OVFL_EN
  logic ovfl_q, ovfl_d;
  assign ovfl_d = ovfl_q | (wrt_smpl & pend_q);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovfl_q <= 1'b0;
    else ovfl_q <= ovfl_d;
  assign ovfl = ovfl_q;
`endif
  // more than DEPTH-TAPS writes per replay would overwrite the window being read
  assert property (@(posedge clk) disable iff (!rst_n) wr_cnt_q <= WW'(DEPTH - TAPS));
endmodule
